rf_wb_arb: RTL

RF_WB_ARB -- requirements
Module: rf_wb_arb

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_wb_fifo.sv | 72 +++++++
 rtl/rf_wb_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file writeback types and constants.
// Used by the writeback arbiter and its long-latency write queue.
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
        logic                  irq;
    } rf_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_LU
    } gnt_e;

    function automatic logic [XLEN-1:0] addr_onehot(
        input logic [REG_ADDR_W-1:0] a
    );
        return XLEN'(1) << a;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular FIFO holding pending long-latency RF writes.
// Exposes per-entry valid bits and addresses for hazard tracking.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic                                 pop,
    input  rf_entry_t                            din,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH):0]               count,
    output rf_entry_t                            head,
    output logic [DEPTH-1:0]                     valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     addrs
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rf_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Entry storage; contents are qualified by valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer, occupancy and per-entry valid bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr         <= wr_ptr + 1'b1;
                valid[wr_ptr]  <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr         <= rd_ptr + 1'b1;
                valid[rd_ptr]  <= 1'b0;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flatten stored destination addresses for the pending-write mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addrs[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter between pipeline writeback and
// queued mul/div results, with starvation-driven pipeline stall.
module rf_wb_arb
    import rf_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_we,
    input  logic [REG_ADDR_W-1:0]   wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    wb_irq,
    input  logic                    mem_wb_freeze,
    input  logic                    lu_valid,
    input  logic [REG_ADDR_W-1:0]   lu_addr,
    input  logic [XLEN-1:0]         lu_data,
    input  logic                    lu_irq,
    output logic                    lu_ready,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_dst_addr,
    output logic [XLEN-1:0]         rf_dst_data,
    output logic                    rf_irq_ctrl_wb,
    output logic                    pipe_stall,
    output logic [XLEN-1:0]         lu_pending,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic                               full;
    logic                               empty;
    logic [$clog2(DEPTH):0]             count;
    rf_entry_t                          head;
    rf_entry_t                          din;
    logic [DEPTH-1:0]                   valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]   addrs;
    logic                               push;
    logic                               pop;
    logic                               starving;
    logic                               wb_ok;
    logic [SW-1:0]                      starve;
    gnt_e                               gnt;

    assign din      = '{addr: lu_addr, data: lu_data, irq: lu_irq};
    assign lu_ready = ~full & ~rst;
    assign push     = lu_valid & lu_ready & (lu_addr != '0);
    assign pop      = (gnt == GNT_LU);
    assign wb_ok    = wb_we & (wb_addr != '0);
    assign starving = ~empty & (starve == SW'(STARVE_MAX));

    assign pipe_stall = starving & ~rst;
    assign q_count    = rst ? '0 : count;

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head),
        .valid (valid),
        .addrs (addrs)
    );

    // Pick the write-port owner: starving head, then wb, then head.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst && !mem_wb_freeze) begin
            if (starving)    gnt = GNT_LU;
            else if (wb_ok)  gnt = GNT_WB;
            else if (!empty) gnt = GNT_LU;
        end
    end

    // Drive the RF write port from the granted source; idle drives zeros.
    always_comb begin
        rf_we          = 1'b0;
        rf_dst_addr    = '0;
        rf_dst_data    = '0;
        rf_irq_ctrl_wb = 1'b0;
        unique case (gnt)
            GNT_WB: begin
                rf_we          = 1'b1;
                rf_dst_addr    = wb_addr;
                rf_dst_data    = wb_data;
                rf_irq_ctrl_wb = wb_irq;
            end
            GNT_LU: begin
                rf_we          = 1'b1;
                rf_dst_addr    = head.addr;
                rf_dst_data    = head.data;
                rf_irq_ctrl_wb = head.irq;
            end
            default: ;
        endcase
    end

    // Count how long the queue head has been waiting for the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (mem_wb_freeze) begin
            starve <= starve;
        end else if (empty || pop) begin
            starve <= '0;
        end else if (starve != SW'(STARVE_MAX)) begin
            starve <= starve + 1'b1;
        end
    end

    // Mask of registers with a write still sitting in the queue.
    always_comb begin
        lu_pending = '0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i]) lu_pending = lu_pending | addr_onehot(addrs[i]);
            end
        end
    end

endmodule
